// File: rtl/bcd_seg_scan_if.sv
// Signal bundle between the result path and the seven-segment scan stage.
// The master drives the BCD word and display controls; the slave drives the display pins.
interface bcd_seg_scan_if;
    logic [31:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    logic        bad_digit;

    modport master (
        output bcd_in, load, blank_lz, dp_mask,
        input  an, seg, dp, frame_tick, bad_digit
    );

    modport slave (
        input  bcd_in, load, blank_lz, dp_mask,
        output an, seg, dp, frame_tick, bad_digit
    );
endinterface

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 8-digit common-anode display driver with leading-zero blanking,
// decimal points and a double-buffered display word that only changes at frame boundaries.
module bcd_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = 20
) (
    input logic          clk,
    input logic          rst_n,
    bcd_seg_scan_if.slave bus
);

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      display;
    logic [31:0]      pending;
    logic             pend_valid;

    logic             tc;
    logic             wrap;
    logic [3:0]       nib;
    logic [7:0]       blank;
    logic             run;
    logic             bad_any;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;
        endcase
    endfunction

    assign tc   = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap = tc && (idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt        <= '0;
            idx            <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            div_cnt        <= tc ? '0 : div_cnt + CNT_W'(1);
            if (tc)
                idx <= idx + 3'd1;
            bus.frame_tick <= wrap;
        end
    end

    // A load on the wrap edge goes straight to the display and leaves nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display    <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            if (bus.load)
                display <= bus.bcd_in;
            else if (pend_valid)
                display <= pending;
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pending    <= bus.bcd_in;
            pend_valid <= 1'b1;
        end
    end

    // Scan from the top digit down; a zero run ends at a non-zero digit or a lit decimal point.
    always_comb begin
        nib     = display[{idx, 2'b00} +: 4];
        blank   = '0;
        run     = bus.blank_lz;
        bad_any = 1'b0;
        for (int unsigned j = 0; j < 7; j++) begin
            run          = run && (display[4*(7-j) +: 4] == 4'd0) && !bus.dp_mask[7-j];
            blank[7-j]   = run;
        end
        for (int unsigned i = 0; i < 8; i++)
            bad_any = bad_any | (display[4*i +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an        <= '1;
            bus.seg       <= '1;
            bus.dp        <= 1'b1;
            bus.bad_digit <= 1'b0;
        end else begin
            if (blank[idx]) begin
                bus.an  <= '1;
                bus.seg <= '1;
                bus.dp  <= 1'b1;
            end else begin
                bus.an  <= ~(8'd1 << idx);
                bus.seg <= seg_code(nib);
                bus.dp  <= ~bus.dp_mask[idx];
            end
            bus.bad_digit <= bad_any;
        end
    end

endmodule
